sine_tone_sequencer: RTL

- Controller that sequences a 1024-entry, 24-bit sine lookup ROM to produce a test tone for the FIR datapath.
- Runs a phase accumulator, derives ROM addresses from it, and paces reads with a programmable sample-rate divider.
- Presents each sample on a valid/ready stream toward the filter input and flags lost samples.
- Supports fixed-length bursts and continuous runs, both started and stopped by control pulses.

---
 rtl/sine_tone_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/sine_tone_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sine_tone_sequencer : paces sine-ROM reads from a phase accumulator and
// streams samples over valid/ready.  Rev 1.0
// ---------------------------------------------------------------------------
module sine_tone_sequencer #(
  parameter int DATA_W  = 24,
  parameter int ADDR_W  = 10,
  parameter int PHASE_W = 16,
  parameter int CNT_W   = 16,
  parameter int DIV_W   = 16
) (
  input  logic               clk,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic [PHASE_W-1:0] phase_inc_i,
  input  logic [CNT_W-1:0]   burst_len_i,
  input  logic [DIV_W-1:0]   div_i,
  output logic               rom_rd_o,
  output logic [ADDR_W-1:0]  rom_addr_o,
  input  logic [DATA_W-1:0]  rom_data_i,
  output logic [DATA_W-1:0]  sample_o,
  output logic               sample_valid_o,
  input  logic               sample_ready_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               overrun_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    CAPTURE = 3'd2,
    PRESENT = 3'd3,
    DRAIN   = 3'd4
  } state_e;

  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);

  state_e               state_q;
  logic [PHASE_W-1:0]   phase_q;
  logic [PHASE_W-1:0]   phase_inc_q;
  logic [CNT_W-1:0]     burst_len_q;
  logic [CNT_W-1:0]     count_q;
  logic [DIV_W-1:0]     div_q;
  logic [DIV_W-1:0]     div_cnt_q;
  logic                 stop_pend_q;
  logic                 rom_rd_q;
  logic [ADDR_W-1:0]    rom_addr_q;
  logic [DATA_W-1:0]    sample_q;
  logic                 valid_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 overrun_q;

  logic tick;
  logic hs;
  logic run_end;

  assign tick    = (div_cnt_q == div_q);
  assign hs      = valid_q && sample_ready_i;
  assign run_end = stop_pend_q || ((burst_len_q != '0) && (count_q == burst_len_q));

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      phase_inc_q <= '0;
      burst_len_q <= '0;
      count_q     <= '0;
      div_q       <= '0;
      div_cnt_q   <= '0;
      stop_pend_q <= 1'b0;
      rom_rd_q    <= 1'b0;
      rom_addr_q  <= '0;
      sample_q    <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      rom_rd_q <= 1'b0;

      if (state_q != IDLE) begin
        div_cnt_q <= tick ? '0 : div_cnt_q + DIV_W'(1);
      end

      if (hs) begin
        valid_q <= 1'b0;
      end

      if (stop_i && (state_q == FETCH || state_q == CAPTURE || state_q == PRESENT)) begin
        stop_pend_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          // busy stays high through the done cycle and drops here
          busy_q <= start_i;
          if (start_i) begin
            phase_inc_q <= phase_inc_i;
            burst_len_q <= burst_len_i;
            div_q       <= (div_i < DIV_MIN) ? DIV_MIN : div_i;
            phase_q     <= '0;
            count_q     <= '0;
            div_cnt_q   <= '0;
            overrun_q   <= 1'b0;
            stop_pend_q <= 1'b0;
            rom_rd_q    <= 1'b1;
            rom_addr_q  <= '0;
            state_q     <= FETCH;
          end
        end
        FETCH: begin
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          sample_q <= rom_data_i;
          valid_q  <= 1'b1;
          phase_q  <= phase_q + phase_inc_q;
          count_q  <= count_q + CNT_W'(1);
          state_q  <= PRESENT;
        end
        PRESENT: begin
          if (tick) begin
            if (valid_q && !sample_ready_i) begin
              overrun_q <= 1'b1;
            end
            if (run_end) begin
              state_q <= DRAIN;
            end else begin
              rom_rd_q   <= 1'b1;
              rom_addr_q <= phase_q[PHASE_W-1 -: ADDR_W];
              state_q    <= FETCH;
            end
          end
        end
        DRAIN: begin
          if (!valid_q || hs) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rom_rd_o       = rom_rd_q;
  assign rom_addr_o     = rom_addr_q;
  assign sample_o       = sample_q;
  assign sample_valid_o = valid_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign overrun_o      = overrun_q;

endmodule
`default_nettype wire
